// File: rtl/sc2bin_ctrl_pkg.sv
// Shared types and width helpers for the sc2bin sequencing controller.
package sc2bin_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WARM  = 3'd2,
        ST_COUNT = 3'd3,
        ST_ACT   = 3'd4,
        ST_PUSH  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // Width of the shift field; a zero MAX_SHFT still needs one bit.
    function automatic int unsigned sw_of(input int unsigned max_shft);
        return (max_shft > 0) ? int'($clog2(max_shft + 1)) : 1;
    endfunction

    // Phase counter must hold 2^BITWIDTH-1 as well as every other phase length.
    function automatic int unsigned cnt_w_of(input int unsigned bitwidth,
                                             input int unsigned warm_cyc,
                                             input int unsigned act_cyc,
                                             input int unsigned row);
        int unsigned w;
        w = bitwidth + 1;
        if (int'($clog2(warm_cyc)) + 1 > int'(w)) w = int'($clog2(warm_cyc)) + 1;
        if (int'($clog2(act_cyc)) + 1 > int'(w))  w = int'($clog2(act_cyc)) + 1;
        if (int'($clog2(row)) + 1 > int'(w))      w = int'($clog2(row)) + 1;
        return w;
    endfunction

endpackage

// File: rtl/sc2bin_seq_cnt.sv
// Loadable down-counter with a zero flag, shared by all timed phases.
module sc2bin_seq_cnt #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sc2bin_seq_ctrl.sv
// Sequencer for one stochastic-to-binary conversion run:
// clear, SNG warm-up, count, activation settle, row push, done.
module sc2bin_seq_ctrl
    import sc2bin_ctrl_pkg::*;
#(
    parameter int unsigned BITWIDTH = 8,
    parameter int unsigned MAX_SHFT = 4,
    parameter int unsigned ROW      = 1,
    parameter int unsigned WARM_CYC = 1,
    parameter int unsigned ACT_CYC  = 2,
    localparam int unsigned SW      = sw_of(MAX_SHFT),
    localparam int unsigned RW      = $clog2(ROW) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [SW-1:0] shft_in,
    output logic          busy,
    output logic          done,
    output logic          arr_rst_n,
    output logic          sng_en,
    output logic          cnt_en,
    output logic          act_en,
    output logic          reg_push,
    output logic [SW-1:0] shft_amt,
    output logic [RW-1:0] row_idx
);

    localparam int unsigned CW = cnt_w_of(BITWIDTH, WARM_CYC, ACT_CYC, ROW);

    state_e        state_q;
    state_e        state_d;
    logic          cnt_load_c;
    logic          cnt_dec_c;
    logic [CW-1:0] cnt_load_val_c;
    logic          cnt_zero_c;
    logic [CW-1:0] count_len_m1_c;
    logic [SW-1:0] shft_clamp_c;

    assign shft_clamp_c   = (32'(shft_in) > MAX_SHFT) ? SW'(MAX_SHFT) : shft_in;
    assign count_len_m1_c = (CW'(1) << (BITWIDTH - 32'(shft_amt))) - CW'(1);

    sc2bin_seq_cnt #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_c),
        .dec      (cnt_dec_c),
        .load_val (cnt_load_val_c),
        .zero_c   (cnt_zero_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each timed phase runs until the counter hits zero, then loads the next length.
    always_comb begin
        state_d        = state_q;
        cnt_load_c     = 1'b0;
        cnt_dec_c      = 1'b0;
        cnt_load_val_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d        = ST_WARM;
                cnt_load_c     = 1'b1;
                cnt_load_val_c = CW'(WARM_CYC - 1);
            end
            ST_WARM: begin
                if (cnt_zero_c) begin
                    state_d        = ST_COUNT;
                    cnt_load_c     = 1'b1;
                    cnt_load_val_c = count_len_m1_c;
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            ST_COUNT: begin
                if (cnt_zero_c) begin
                    state_d        = ST_ACT;
                    cnt_load_c     = 1'b1;
                    cnt_load_val_c = CW'(ACT_CYC - 1);
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            ST_ACT: begin
                if (cnt_zero_c) begin
                    state_d        = ST_PUSH;
                    cnt_load_c     = 1'b1;
                    cnt_load_val_c = CW'(ROW - 1);
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            ST_PUSH: begin
                if (cnt_zero_c) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_dec_c = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            arr_rst_n <= 1'b0;
            sng_en    <= 1'b0;
            cnt_en    <= 1'b0;
            act_en    <= 1'b0;
            reg_push  <= 1'b0;
            row_idx   <= '0;
            shft_amt  <= '0;
        end else begin
            busy      <= (state_d != ST_IDLE);
            done      <= (state_d == ST_DONE);
            arr_rst_n <= !((state_d == ST_IDLE) || (state_d == ST_CLEAR));
            sng_en    <= (state_d == ST_WARM) || (state_d == ST_COUNT);
            cnt_en    <= (state_d == ST_COUNT);
            act_en    <= (state_d == ST_ACT) || (state_d == ST_PUSH);
            reg_push  <= (state_d == ST_PUSH);
            row_idx   <= ((state_d == ST_PUSH) && (state_q == ST_PUSH)) ? row_idx + RW'(1) : '0;
            if ((state_q == ST_IDLE) && start) begin
                shft_amt <= shft_clamp_c;
            end
        end
    end

endmodule

// File: tb/tb_sc2bin_seq_ctrl.sv
// Directed bench for sc2bin_seq_ctrl: ROW=1 instance for run timing, ROW=3 instance for push rows.
module tb_sc2bin_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] shft_in;

    logic       busy, done, arr_rst_n, sng_en, cnt_en, act_en, reg_push;
    logic [2:0] shft_amt;
    logic [0:0] row_idx;

    logic       busy3, done3, arr_rst_n3, sng_en3, cnt_en3, act_en3, reg_push3;
    logic [2:0] shft_amt3;
    logic [2:0] row_idx3;

    int n_assert = 0;
    int n_fail   = 0;

    sc2bin_seq_ctrl #(
        .BITWIDTH (8), .MAX_SHFT (4), .ROW (1), .WARM_CYC (1), .ACT_CYC (2)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .shft_in (shft_in),
        .busy (busy), .done (done), .arr_rst_n (arr_rst_n), .sng_en (sng_en),
        .cnt_en (cnt_en), .act_en (act_en), .reg_push (reg_push),
        .shft_amt (shft_amt), .row_idx (row_idx)
    );

    sc2bin_seq_ctrl #(
        .BITWIDTH (8), .MAX_SHFT (4), .ROW (3), .WARM_CYC (1), .ACT_CYC (2)
    ) dut3 (
        .clk (clk), .reset (reset), .start (start), .shft_in (shft_in),
        .busy (busy3), .done (done3), .arr_rst_n (arr_rst_n3), .sng_en (sng_en3),
        .cnt_en (cnt_en3), .act_en (act_en3), .reg_push (reg_push3),
        .shft_amt (shft_amt3), .row_idx (row_idx3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] shft;
        int         amt;
        int         n;
        int         done_c;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue start at edge 0, then sample cycles 1..done_c+3 one time unit after each edge.
    task automatic run_vec(input vec_t v, input int pulse_a, input int pulse_b);
        int  cnt_n, first_cnt, last_cnt, done_at, done_n;
        bit  amt_ok, idle_ok, warm_ok;
        cnt_n = 0; first_cnt = 0; last_cnt = 0; done_at = 0; done_n = 0;
        amt_ok = 1'b1; idle_ok = 1'b1; warm_ok = 1'b1;
        @(negedge clk);
        start   = 1'b1;
        shft_in = v.shft;
        @(posedge clk); #1;
        check($sformatf("clear_state shft=%0d", v.shft),
              int'({busy, arr_rst_n, sng_en}), 4);
        for (int c = 1; c <= v.done_c + 3; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            start   = (c == pulse_a) || (c == pulse_b);
            shft_in = 3'($urandom);
            if (cnt_en) begin
                if (cnt_n == 0) first_cnt = c;
                cnt_n++;
                last_cnt = c;
            end
            if (c == 2 && !(sng_en && !cnt_en)) warm_ok = 1'b0;
            if (done) begin
                done_n++;
                done_at = c;
            end
            if (busy && int'(shft_amt) != v.amt) amt_ok = 1'b0;
            if (c > v.done_c && busy) idle_ok = 1'b0;
        end
        start = 1'b0;
        check($sformatf("done_cycle shft=%0d", v.shft), done_at, v.done_c);
        check($sformatf("done_pulses shft=%0d", v.shft), done_n, 1);
        check($sformatf("cnt_cycles shft=%0d", v.shft), cnt_n, v.n);
        check($sformatf("cnt_first shft=%0d", v.shft), first_cnt, 3);
        check($sformatf("cnt_contiguous shft=%0d", v.shft), last_cnt - first_cnt + 1, v.n);
        check($sformatf("warm_enables shft=%0d", v.shft), int'(warm_ok), 1);
        check($sformatf("shft_amt_held shft=%0d", v.shft), int'(amt_ok), 1);
        check($sformatf("idle_after_done shft=%0d", v.shft), int'(idle_ok), 1);
    endtask

    initial begin
        int done_n, busy_n, act_n, push_n, first_push, done_at;
        int rows[3];

        vecs[0] = '{shft: 3'd0, amt: 0, n: 256, done_c: 262};
        vecs[1] = '{shft: 3'd4, amt: 4, n: 16,  done_c: 22};
        vecs[2] = '{shft: 3'd7, amt: 4, n: 16,  done_c: 22};
        vecs[3] = '{shft: 3'd1, amt: 1, n: 128, done_c: 134};
        vecs[4] = '{shft: 3'd3, amt: 3, n: 32,  done_c: 38};
        vecs[5] = '{shft: 3'd5, amt: 4, n: 16,  done_c: 22};

        reset   = 1'b1;
        start   = 1'b0;
        shft_in = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", int'({busy, done, arr_rst_n, sng_en, cnt_en, act_en, reg_push}), 0);
        check("reset_fields", int'({shft_amt, row_idx}), 0);
        check("reset_row3", int'({busy3, done3, arr_rst_n3, reg_push3, row_idx3, shft_amt3}), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], 0, 0);
        end

        // Start pulses during COUNT and during DONE must be ignored.
        run_vec(vecs[1], 10, 22);

        // Reset in the fifth COUNT cycle aborts the run without a done pulse.
        @(negedge clk);
        start   = 1'b1;
        shft_in = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            @(posedge clk); #1;
        end
        check("count_before_abort", int'(cnt_en), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_ctrl", int'({busy, done, arr_rst_n, sng_en, cnt_en, act_en, reg_push}), 0);
        check("abort_fields", int'({shft_amt, row_idx}), 0);
        done_n = 0;
        busy_n = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) done_n++;
            if (busy) busy_n++;
        end
        check("abort_no_done", done_n, 0);
        check("abort_stays_idle", busy_n, 0);
        run_vec(vecs[1], 0, 0);

        // Three-row push on the ROW=3 instance.
        act_n = 0; push_n = 0; first_push = 0; done_at = 0;
        rows[0] = -1; rows[1] = -1; rows[2] = -1;
        @(negedge clk);
        start   = 1'b1;
        shft_in = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (act_en3) act_n++;
            if (reg_push3) begin
                if (push_n == 0) first_push = c;
                if (push_n < 3) rows[push_n] = int'(row_idx3);
                push_n++;
            end
            if (done3) done_at = c;
        end
        check("row3_act_cycles", act_n, 5);
        check("row3_push_cycles", push_n, 3);
        check("row3_first_push", first_push, 21);
        check("row3_idx0", rows[0], 0);
        check("row3_idx1", rows[1], 1);
        check("row3_idx2", rows[2], 2);
        check("row3_done_cycle", done_at, 24);
        check("row3_idx_idle", int'(row_idx3), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sc2bin_seq_ctrl.md
SC2BIN_SEQ_CTRL -- requirements
Module: sc2bin_seq_ctrl

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 8: stochastic stream length exponent, matching the array.
REQ-002 The block SHALL have parameter MAX_SHFT, default 4: maximum shift amount, matching the array.
REQ-003 The block SHALL have parameter ROW, default 1: number of array rows pushed out.
REQ-004 The block SHALL have parameter WARM_CYC, default 1 (>=1): cycles of SNG warm-up before counting.
REQ-005 The block SHALL have parameter ACT_CYC, default 2 (>=1): cycles of activation settle before push.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: request one conversion run.
REQ-009 The block SHALL have port shft_in, input, SW bits: requested shift, where SW = (MAX_SHFT>0 ? clog2(MAX_SHFT+1) : 1).
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.
REQ-012 The block SHALL have port arr_rst_n, output, 1 bit: active-low clear to the sc2bin array.
REQ-013 The block SHALL have ports sng_en, cnt_en, act_en and reg_push, each output, 1 bit: drive the same-named array and SNG inputs.
REQ-014 The block SHALL have port shft_amt, output, SW bits: latched shift sent to the array.
REQ-015 The block SHALL have port row_idx, output, clog2(ROW)+1 bits: index of the row being pushed.

Function
REQ-016 The FSM SHALL have states IDLE, CLEAR, WARM, COUNT, ACT, PUSH and DONE.
REQ-017 In IDLE, start=1 SHALL latch shft_amt = min(shft_in, MAX_SHFT) and move to CLEAR; start SHALL be ignored in every other state.
REQ-018 CLEAR SHALL last 1 cycle with arr_rst_n=0; arr_rst_n SHALL be 0 in IDLE and CLEAR and 1 in all other states.
REQ-019 WARM SHALL last WARM_CYC cycles with sng_en=1 and cnt_en=0.
REQ-020 COUNT SHALL last exactly N = 2^(BITWIDTH - shft_amt) cycles with sng_en=1 and cnt_en=1, using a down-counter of BITWIDTH+1 bits loaded with N-1.
REQ-021 ACT SHALL last ACT_CYC cycles with act_en=1 and sng_en=cnt_en=0.
REQ-022 PUSH SHALL last ROW cycles with act_en=1 and reg_push=1, and row_idx SHALL count 0..ROW-1, one step per cycle.
REQ-023 DONE SHALL last 1 cycle with done=1 and all enables 0, then return to IDLE; start asserted during DONE SHALL be ignored.
REQ-024 Run latency SHALL be fixed: if start is sampled at edge 0, done SHALL be high in cycle 2+WARM_CYC+N+ACT_CYC+ROW.
REQ-025 All outputs SHALL be registered, with no combinational path from start or shft_in to any output.
REQ-026 shft_amt SHALL hold its latched value from CLEAR through DONE, independent of later changes on shft_in.

Reset
REQ-027 While reset=1 at a clock edge, the state SHALL become IDLE, all counters 0, and busy, done, sng_en, cnt_en, act_en, reg_push, row_idx and shft_amt 0, with arr_rst_n=0.
REQ-028 reset asserted mid-run (any state) SHALL abort the run on the next edge with no done pulse.

Structure
REQ-029 Package sc2bin_ctrl_pkg SHALL hold the state enum and the SW and counter-width constant functions.
REQ-030 One sub-module, sc2bin_seq_cnt (a loadable down-counter with a zero flag), SHALL be reused for the WARM, COUNT, ACT and PUSH phase timing.

Verification (BITWIDTH=8, ROW=1, WARM_CYC=1, ACT_CYC=2)
REQ-031 start with shft_in=0 -> cnt_en high for exactly 256 consecutive cycles; done high in cycle 262.
REQ-032 start with shft_in=4 -> cnt_en high for 16 cycles; done in cycle 22; shft_amt=4 throughout.
REQ-033 start with shft_in=7 -> clamped: shft_amt=4, cnt_en high for 16 cycles.
REQ-034 start pulsed during COUNT and during DONE -> ignored; exactly one done pulse; IDLE follows DONE.
REQ-035 reset=1 in COUNT cycle 5 -> next cycle all outputs 0, arr_rst_n=0, no done; a new start then runs normally.
REQ-036 ROW=3 -> reg_push high for 3 cycles with row_idx 0,1,2; act_en high for 5 cycles total.
